// File: rtl/ram_dp_be.sv
// ram_dp_be: two-port (A = CPU data, B = debug monitor) word RAM with byte enables.
// Latency: WAIT_STATES+1 edges from accept to ready; one access per WAIT_STATES+3 cycles.
// Backpressure: requester holds req and its signals until the one-cycle ready pulse; round-robin on ties.
//
// Ports:
//   clk, reset            clock (rising edge) and asynchronous active-high reset
//   x_req / x_ready       request level and completion pulse for port x (a or b)
//   x_we, x_be            write(1)/read(0) and per-byte-lane write enables
//   x_addr, x_wd          byte address and write data
//   x_rd                  registered read data, held until the port's next read/error
//   x_err                 out-of-window flag, valid together with x_ready
module ram_dp_be #(
  parameter int          ADDR_BITS   = 11,
  parameter int          DATA_WIDTH  = 32,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [31:0]             a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wd,
  output logic [DATA_WIDTH-1:0]   a_rd,
  output logic                    a_ready,
  output logic                    a_err,

  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [31:0]             b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wd,
  output logic [DATA_WIDTH-1:0]   b_rd,
  output logic                    b_ready,
  output logic                    b_err
);

  localparam int          NB    = DATA_WIDTH / 8;
  localparam int          LSB   = (NB > 1) ? $clog2(NB) : 0;
  localparam int          HI    = ADDR_BITS + LSB;
  localparam int          DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0]  WS    = WAIT_STATES[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   last_b;   // 1: port B won the most recent tie
  logic                   gnt_b;    // port owning the in-flight access
  logic                   l_we;
  logic [NB-1:0]          l_be;
  logic [ADDR_BITS-1:0]   l_idx;
  logic                   l_inr;
  logic [DATA_WIDTH-1:0]  l_wd;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   pick_b;
  logic [31:0]            sel_addr;
  logic                   sel_inr;
  logic                   access;
  logic [DATA_WIDTH-1:0]  rword;

  // Address bits outside the word index only feed the window compare;
  // this sink keeps the low (byte-offset) bits from being flagged as dead.
  logic                   unused_addr_bits;
  assign unused_addr_bits = ^{a_addr, b_addr};

  // On a tie the port that did not win the previous tie is served.
  always_comb begin
    pick_b   = b_req && (!a_req || !last_b);
    sel_addr = pick_b ? b_addr : a_addr;
    sel_inr  = (sel_addr >> HI) == (BASE_ADDR >> HI);
  end

  assign access = (state == S_WAIT) && (cnt == 4'd0);
  assign rword  = mem[l_idx];

  // Array is not reset; an aborted transaction never reaches S_WAIT/cnt==0
  // because reset clears the FSM asynchronously.
  always_ff @(posedge clk) begin
    if (access && l_inr && l_we) begin
      for (int i = 0; i < NB; i++) begin
        if (l_be[i]) begin
          mem[l_idx][8*i +: 8] <= l_wd[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      last_b  <= 1'b1;
      gnt_b   <= 1'b0;
      l_we    <= 1'b0;
      l_be    <= '0;
      l_idx   <= '0;
      l_inr   <= 1'b0;
      l_wd    <= '0;
      a_rd    <= '0;
      a_ready <= 1'b0;
      a_err   <= 1'b0;
      b_rd    <= '0;
      b_ready <= 1'b0;
      b_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (a_req || b_req) begin
            gnt_b <= pick_b;
            if (a_req && b_req) begin
              last_b <= pick_b;
            end
            l_we  <= pick_b ? b_we : a_we;
            l_be  <= pick_b ? b_be : a_be;
            l_idx <= sel_addr[HI-1:LSB];
            l_inr <= sel_inr;
            l_wd  <= pick_b ? b_wd : a_wd;
            cnt   <= WS;
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= S_DONE;
            if (gnt_b) begin
              b_ready <= 1'b1;
              b_err   <= !l_inr;
              if (!l_inr) begin
                b_rd <= '0;
              end else if (!l_we) begin
                b_rd <= rword;
              end
            end else begin
              a_ready <= 1'b1;
              a_err   <= !l_inr;
              if (!l_inr) begin
                a_rd <= '0;
              end else if (!l_we) begin
                a_rd <= rword;
              end
            end
          end
        end

        S_DONE: begin
          // Requests seen here are held off until the return to idle.
          if (gnt_b) begin
            b_ready <= 1'b0;
            b_err   <= 1'b0;
          end else begin
            a_ready <= 1'b0;
            a_err   <= 1'b0;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: random and directed traffic on both ports, scoreboarded against a word-array model.
// Latency: checks accept-to-ready, ready pulse width and spacing under continuous demand.
// Backpressure: requests held until ready; per-port expectation queues popped on each ready pulse.
module tb_ram_dp_be;

  localparam int WS  = 3;
  localparam int TO  = 200;
  localparam logic [31:0] WIN = 32'h0000_2000;   // 2**11 words of 4 bytes, base 0

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        req = '0;
  logic [1:0]        we  = '0;
  logic [1:0][3:0]   be  = '0;
  logic [1:0][31:0]  addr = '0;
  logic [1:0][31:0]  wd  = '0;
  logic [1:0][31:0]  rd;
  logic [1:0]        rdy;
  logic [1:0]        err;

  always #5 clk = ~clk;

  ram_dp_be #(
    .ADDR_BITS  (11),
    .DATA_WIDTH (32),
    .WAIT_STATES(WS),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .a_req  (req[0]),
    .a_we   (we[0]),
    .a_be   (be[0]),
    .a_addr (addr[0]),
    .a_wd   (wd[0]),
    .a_rd   (rd[0]),
    .a_ready(rdy[0]),
    .a_err  (err[0]),
    .b_req  (req[1]),
    .b_we   (we[1]),
    .b_be   (be[1]),
    .b_addr (addr[1]),
    .b_wd   (wd[1]),
    .b_rd   (rd[1]),
    .b_ready(rdy[1]),
    .b_err  (err[1])
  );

  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mm [0:2047];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          phase = 0;
  bit          multi_en = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req_v, $time);
    end
  endtask

  // Reference behaviour: a byte-addressed window of words; bytes outside it
  // are rejected, writes merge only the enabled byte lanes.
  task automatic model(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, output exp_t e);
    int idx;
    e.we  = w;
    e.err = 1'b0;
    e.rd  = '0;
    if (a >= WIN) begin
      e.err = 1'b1;
    end else begin
      idx = int'(a / 4);
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) mm[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        e.rd = mm[idx];
      end
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    model(w, b, a, d, e);
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
    we[p]   = w;
    be[p]   = b;
    addr[p] = a;
    wd[p]   = d;
    req[p]  = 1'b1;
  endtask

  // Returns the number of falling edges until ready is seen.
  task automatic wait_ready(input int p, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[p] && n < TO);
    if (!rdy[p]) check($sformatf("port%0d_ready_timeout", p), 32'(rdy[p]), 32'd1);
  endtask

  task automatic single(input int p, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input bit chk_lat);
    int n;
    issue(p, w, b, a, d);
    wait_ready(p, n);
    req[p] = 1'b0;
    // Issued while idle: accept edge, then WS+1 more edges to ready.
    if (chk_lat) check($sformatf("port%0d_latency", p), 32'(n), 32'(WS + 2));
    @(negedge clk);
  endtask

  // mode 0: fill own pool; mode 1: repeated reads of one word; mode 2: random.
  task automatic stream(input int p, input int cnt, input int mode);
    int n;
    int base;
    int word;
    int op;
    logic [31:0] a;
    base = (p == 0) ? 0 : 32;
    for (int i = 0; i < cnt; i++) begin
      if (mode == 0) begin
        issue(p, 1'b1, 4'hF, 32'((base + i) * 4),
              (p == 0 && i == 4) ? 32'hDEAD_BEEF : $urandom);
      end else if (mode == 1) begin
        issue(p, 1'b0, 4'hF, (p == 0) ? 32'h10 : 32'h20, 32'h0);
      end else begin
        word = base + $urandom_range(0, 15);
        op   = $urandom_range(0, 9);
        a    = 32'(word * 4) | 32'($urandom_range(0, 3));
        if (op == 0)
          issue(p, 1'($urandom_range(0, 1)), 4'($urandom), (32'($urandom_range(1, 19'h7FFFF)) << 13) | 32'(word * 4), $urandom);
        else if (op <= 4)
          issue(p, 1'b1, 4'($urandom), a, $urandom);
        else
          issue(p, 1'b0, 4'($urandom), a, $urandom);
      end
      wait_ready(p, n);
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        req[p] = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req[p] = 1'b0;
  endtask

  // Monitor: pops the port's expectation on each rising ready and tracks rd.
  logic [1:0]       prev_rdy = '0;
  logic [1:0][31:0] exp_rd = '0;
  int               mphase = -1;
  int               first_port = -1;
  int               last_port = 0;
  int               last_cyc = 0;
  bit               have_last = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   empty;
    if (reset) begin
      q0.delete();
      q1.delete();
      exp_rd   = '0;
      prev_rdy = '0;
    end else begin
      if (mphase != phase) begin
        mphase     = phase;
        have_last  = 0;
        first_port = -1;
      end
      check("ready_exclusive", 32'(rdy[0] & rdy[1]), 32'd0);
      for (int p = 0; p < 2; p++) begin
        if (rdy[p]) begin
          check($sformatf("port%0d_ready_width", p), 32'(prev_rdy[p]), 32'd0);
          if (!prev_rdy[p]) begin
            empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
              check($sformatf("port%0d_unexpected_ready", p), 32'd1, 32'd0);
            end else begin
              if (p == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              check($sformatf("port%0d_err", p), 32'(err[p]), 32'(e.err));
              if (!e.we || e.err) exp_rd[p] = e.rd;
              if (multi_en) begin
                if (first_port < 0) first_port = p;
                if (have_last) begin
                  check("grant_alternation", 32'(p), 32'(1 - last_port));
                  check("grant_spacing", 32'(cyc - last_cyc), 32'(WS + 3));
                end
                have_last = 1;
                last_port = p;
                last_cyc  = cyc;
              end
            end
          end
        end else begin
          check($sformatf("port%0d_err_idle", p), 32'(err[p]), 32'd0);
        end
        check($sformatf("port%0d_rd", p), rd[p], exp_rd[p]);
      end
      prev_rdy = rdy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] old;

    #2 reset = 1'b1;
    #1;
    check("reset_a_rd", rd[0], 32'd0);
    check("reset_b_rd", rd[1], 32'd0);
    check("reset_ready", 32'(rdy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Both ports fill their pools under constant contention; A wins the first tie.
    phase = 1;
    multi_en = 1;
    fork
      stream(0, 16, 0);
      stream(1, 16, 0);
    join
    check("first_tie_winner", 32'(first_port), 32'd0);
    multi_en = 0;
    phase = 2;
    @(negedge clk);
    @(negedge clk);

    single(0, 1'b0, 4'hF, 32'h10, 32'h0, 1);
    check("read_deadbeef", rd[0], 32'hDEAD_BEEF);
    single(0, 1'b1, 4'b0101, 32'h10, 32'h1122_3344, 1);
    single(0, 1'b0, 4'hF, 32'h10, 32'h0, 1);
    check("byte_merge", rd[0], 32'hDE22_BE44);
    single(0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 1);
    single(0, 1'b0, 4'hF, 32'h10, 32'h0, 1);
    check("be_zero_noop", rd[0], 32'hDE22_BE44);

    single(0, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 1);
    check("oor_read_zero", rd[0], 32'd0);
    single(0, 1'b1, 4'hF, 32'h0000_2000, 32'h5555_5555, 1);
    single(0, 1'b0, 4'hF, 32'h0, 32'h0, 1);
    single(1, 1'b0, 4'hF, 32'h20, 32'h0, 1);

    single(1, 1'b1, 4'hF, 32'h10, 32'hA5A5_5A5A, 0);
    single(0, 1'b0, 4'hF, 32'h10, 32'h0, 0);
    check("cross_port_read", rd[0], 32'hA5A5_5A5A);

    phase = 3;
    multi_en = 1;
    fork
      stream(0, 6, 1);
      stream(1, 6, 1);
    join
    multi_en = 0;
    phase = 4;
    @(negedge clk);
    @(negedge clk);

    fork
      stream(0, 60, 2);
      stream(1, 60, 2);
    join
    @(negedge clk);
    @(negedge clk);

    // Abort a write to 0x10 while it is still counting wait states.
    phase = 5;
    old = mm[4];
    issue(0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D);
    mm[4] = old;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_a_rd", rd[0], 32'd0);
    check("abort_b_rd", rd[1], 32'd0);
    check("abort_ready", 32'(rdy), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    req = '0;
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    single(0, 1'b0, 4'hF, 32'h10, 32'h0, 1);
    check("abort_no_write", rd[0], old);

    repeat (4) @(negedge clk);
    check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
